// File: rtl/shift_right_unit_if.sv
// Request/response bundle for the iterative right shifter.
//   i_start  request strobe, sampled by the shifter only in IDLE or DONE
//   i_data   operand (rt)
//   i_shamt  shift amount (shamt field or rs[4:0])
//   i_arith  1 = arithmetic (sign fill), 0 = logical (zero fill)
//   o_data   registered result, held until the next result
//   o_busy   high while shifting
//   o_done   one-cycle pulse, o_data valid in that cycle
// master = requester (control unit / bench), slave = shifter.
interface shift_right_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               i_start;
  logic [WIDTH-1:0]   i_data;
  logic [SHAMT_W-1:0] i_shamt;
  logic               i_arith;
  logic [WIDTH-1:0]   o_data;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_data, i_shamt, i_arith,
    input  o_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_data, i_shamt, i_arith,
    output o_data, o_busy, o_done
  );
endinterface

// File: rtl/shift_right_unit.sv
// Iterative right shifter (SRL/SRA/SRLV/SRAV), one bit per clock.
//   i_clk  rising-edge clock
//   i_rst  asynchronous reset, active-high
//   bus    shift_right_unit_if.slave: start/operands in, data/busy/done out
// A request loads the operand, count and fill bit, then SHIFT runs count+1
// cycles (the final one moves the result into o_data) before a one-cycle DONE.
// A new request in DONE reloads directly, so back-to-back ops have no bubble.
module shift_right_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  shift_right_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               fill_q,  fill_d;
  logic [WIDTH-1:0]   data_q,  data_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    fill_d  = fill_q;
    data_d  = data_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          shreg_d = bus.i_data;
          count_d = bus.i_shamt;
          // sign captured once so the fill stays correct for every shamt
          fill_d  = bus.i_arith & bus.i_data[WIDTH-1];
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (count_q != '0) begin
          shreg_d = {fill_q, shreg_q[WIDTH-1:1]};
          count_d = count_q - SHAMT_W'(1);
        end else begin
          data_d  = shreg_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_data = data_q;
  assign bus.o_busy = (state_q == SHIFT);
  assign bus.o_done = (state_q == DONE);

endmodule
